// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch/sequencer core and its execute-side
// control unit: core state codes, opcode values, instruction field
// positions, flag bit indices and small opcode-class decode helpers.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int NUM_REGS = 4;
    localparam int STEP_W   = 16;

    // Core sequencer state codes (shared with cpu_core)
    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } core_state_e;

    // Control-unit step tracking
    typedef enum logic [0:0] {
        CU_IDLE = 1'b0,
        CU_PEND = 1'b1
    } cu_state_e;

    // Opcodes (ir[31:24])
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_MOV = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_OR  = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;
    localparam logic [7:0] OP_CMP = 8'h08;
    localparam logic [7:0] OP_JMP = 8'h09;
    localparam logic [7:0] OP_JZ  = 8'h0A;
    localparam logic [7:0] OP_JNZ = 8'h0B;
    localparam logic [7:0] OP_JC  = 8'h0C;
    localparam logic [7:0] OP_OUT = 8'h0D;
    localparam logic [7:0] OP_HLT = 8'hFF;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;
    localparam int RD_MSB  = 17;
    localparam int RD_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 8;
    localparam int RS_MSB  = 1;
    localparam int RS_LSB  = 0;

    // Flag bit indices
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    // Opcode writes a result into rd
    function automatic logic writes_rd(input logic [7:0] op);
        case (op)
            OP_LDI, OP_MOV, OP_ADD, OP_SUB,
            OP_AND, OP_OR,  OP_XOR:          writes_rd = 1'b1;
            default:                         writes_rd = 1'b0;
        endcase
    endfunction

    // Opcode updates Z/C
    function automatic logic updates_flags(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_CMP:                  updates_flags = 1'b1;
            default:                         updates_flags = 1'b0;
        endcase
    endfunction

    // Opcode belongs to the instruction set
    function automatic logic is_defined(input logic [7:0] op);
        case (op)
            OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_CMP, OP_JMP, OP_JZ,  OP_JNZ, OP_JC,  OP_OUT, OP_HLT:
                                             is_defined = 1'b1;
            default:                         is_defined = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_if
// Bus between the fetch/sequencer core (master) and the execute-side
// control unit (slave).
//   ir, clks, state                : core -> control unit
//   end_inst, jmp_inst, jmp_address,
//   inst_condition, hlt_inst,
//   out_data, out_valid            : control unit -> core / OUT port
//   illegal_op                     : only with CPU_CTRL_ILLEGAL_TRAP_EN
// ----------------------------------------------------------------------------
interface cpu_ctrl_if
    import cpu_pkg::*;
();
    logic [31:0]       ir;
    logic [STEP_W-1:0] clks;
    logic [1:0]        state;
    logic              end_inst;
    logic              jmp_inst;
    logic [7:0]        jmp_address;
    logic              inst_condition;
    logic              hlt_inst;
    logic [7:0]        out_data;
    logic              out_valid;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic              illegal_op;

    modport master (
        output ir, clks, state,
        input  end_inst, jmp_inst, jmp_address, inst_condition, hlt_inst,
               out_data, out_valid, illegal_op
    );

    modport slave (
        input  ir, clks, state,
        output end_inst, jmp_inst, jmp_address, inst_condition, hlt_inst,
               out_data, out_valid, illegal_op
    );
`else
    modport master (
        output ir, clks, state,
        input  end_inst, jmp_inst, jmp_address, inst_condition, hlt_inst,
               out_data, out_valid
    );

    modport slave (
        input  ir, clks, state,
        output end_inst, jmp_inst, jmp_address, inst_condition, hlt_inst,
               out_data, out_valid
    );
`endif
endinterface

// File: rtl/cpu_alu.sv
// ----------------------------------------------------------------------------
// cpu_alu
// Combinational 8-bit ALU for the control unit.
//   op  : opcode (ir[31:24]); LDI/MOV pass b through
//   a   : rd value, b : rs value or immediate
//   res : result, z : res==0, c : carry (ADD) / borrow (SUB, CMP), else 0
// ----------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] res,
    output logic       z,
    output logic       c
);

    logic [8:0] sum_s;

    // Result and carry/borrow selection per opcode
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b};
        res   = 8'h00;
        c     = 1'b0;
        case (op)
            OP_LDI, OP_MOV: res = b;
            OP_ADD: begin
                res = sum_s[7:0];
                c   = sum_s[8];
            end
            OP_SUB, OP_CMP: begin
                res = a - b;
                c   = (a < b);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = 8'h00;
        endcase
        z = (res == 8'h00);
    end

endmodule

// File: rtl/cpu_control_unit.sv
// ----------------------------------------------------------------------------
// cpu_control_unit
// Execute-side partner of the fetch/sequencer core. Each instruction takes
// two steps while the core is in EXEC: at the clks[0] edge the instruction
// is decoded, operands read and the result/flags computed; control outputs
// are registered so they are high during the clks[1] cycle. At the clks[1]
// edge rd and Z/C are written back and the control outputs drop.
// Ports:
//   clk   : system clock (posedge)
//   reset : synchronous, active-high
//   bus   : cpu_ctrl_if.slave (ir/clks/state in; end_inst, jmp_inst,
//           jmp_address, inst_condition, hlt_inst, out_data, out_valid out)
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN adds bus.illegal_op;
// undefined opcodes then trap (illegal_op + hlt_inst sticky). Without it
// undefined opcodes behave as NOP.
// ----------------------------------------------------------------------------
module cpu_control_unit
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    cpu_ctrl_if.slave      bus
);

    // Instruction fields
    logic [7:0] opc_s;
    logic [1:0] rd_s;
    logic [1:0] rs_s;
    logic [7:0] imm_s;
    logic [7:0] rd_val_s;
    logic [7:0] rs_val_s;
    logic [7:0] alu_b_s;
    logic [7:0] alu_res_s;
    logic       alu_z_s;
    logic       alu_c_s;
    logic       step0_s;
    logic       commit_s;
    logic       squash_s;
    logic       unused_s;

    // State
    cu_state_e                  ex_state_q, ex_state_d;
    logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
    logic                       z_q, z_d;
    logic                       c_q, c_d;
    logic                       hlt_q, hlt_d;
    logic [1:0]                 rd_idx_q, rd_idx_d;
    logic [7:0]                 res_q, res_d;
    logic                       z_new_q, z_new_d;
    logic                       c_new_q, c_new_d;
    logic                       wr_rd_q, wr_rd_d;
    logic                       wr_fl_q, wr_fl_d;
    logic                       end_inst_q, end_inst_d;
    logic                       jmp_inst_q, jmp_inst_d;
    logic [7:0]                 jmp_address_q, jmp_address_d;
    logic                       cond_q, cond_d;
    logic [7:0]                 out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic                       illegal_q, illegal_d;
`endif

    assign opc_s    = bus.ir[OPC_MSB:OPC_LSB];
    assign rd_s     = bus.ir[RD_MSB:RD_LSB];
    assign rs_s     = bus.ir[RS_MSB:RS_LSB];
    assign imm_s    = bus.ir[IMM_MSB:IMM_LSB];
    assign rd_val_s = regs_q[rd_s];
    assign rs_val_s = regs_q[rs_s];
    // Reserved ir bits and step strobes beyond 1 carry no meaning here
    assign unused_s = ^{bus.ir[23:18], bus.ir[7:2], bus.clks[STEP_W-1:2]};

    assign step0_s  = (bus.state == ST_EXEC) && bus.clks[0] && !hlt_q;
    assign commit_s = (ex_state_q == CU_PEND) && (bus.state == ST_EXEC) && bus.clks[1];
    assign squash_s = (ex_state_q == CU_PEND) && (bus.state != ST_EXEC);

    // LDI feeds the immediate through the ALU's pass-through path
    always_comb begin
        alu_b_s = rs_val_s;
        if (opc_s == OP_LDI) begin
            alu_b_s = imm_s;
        end else begin
            alu_b_s = rs_val_s;
        end
    end

    cpu_alu u_alu (
        .op  (opc_s),
        .a   (rd_val_s),
        .b   (alu_b_s),
        .res (alu_res_s),
        .z   (alu_z_s),
        .c   (alu_c_s)
    );

    // Step tracking, decode/latch at step0, writeback at step1
    always_comb begin
        ex_state_d    = ex_state_q;
        regs_d        = regs_q;
        z_d           = z_q;
        c_d           = c_q;
        hlt_d         = hlt_q;
        rd_idx_d      = rd_idx_q;
        res_d         = res_q;
        z_new_d       = z_new_q;
        c_new_d       = c_new_q;
        wr_rd_d       = wr_rd_q;
        wr_fl_d       = wr_fl_q;
        end_inst_d    = end_inst_q;
        jmp_inst_d    = jmp_inst_q;
        jmp_address_d = jmp_address_q;
        cond_d        = cond_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        illegal_d     = illegal_q;
`endif
        case (ex_state_q)
            CU_IDLE: begin
                if (step0_s) begin
                    ex_state_d    = CU_PEND;
                    rd_idx_d      = rd_s;
                    res_d         = alu_res_s;
                    z_new_d       = alu_z_s;
                    c_new_d       = alu_c_s;
                    wr_rd_d       = writes_rd(opc_s);
                    wr_fl_d       = updates_flags(opc_s);
                    end_inst_d    = 1'b1;
                    jmp_inst_d    = 1'b0;
                    jmp_address_d = 8'h00;
                    cond_d        = 1'b1;
                    out_valid_d   = 1'b0;
                    // Conditions use the flags as they stand before this instruction
                    case (opc_s)
                        OP_JMP: begin
                            jmp_inst_d    = 1'b1;
                            jmp_address_d = imm_s;
                        end
                        OP_JZ: begin
                            jmp_inst_d    = 1'b1;
                            jmp_address_d = imm_s;
                            cond_d        = z_q;
                        end
                        OP_JNZ: begin
                            jmp_inst_d    = 1'b1;
                            jmp_address_d = imm_s;
                            cond_d        = !z_q;
                        end
                        OP_JC: begin
                            jmp_inst_d    = 1'b1;
                            jmp_address_d = imm_s;
                            cond_d        = c_q;
                        end
                        OP_OUT: begin
                            out_valid_d = 1'b1;
                            out_data_d  = rs_val_s;
                        end
                        OP_HLT: begin
                            end_inst_d = 1'b0;
                            cond_d     = 1'b0;
                            hlt_d      = 1'b1;
                        end
                        default: begin
                            if (!is_defined(opc_s)) begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                                end_inst_d = 1'b0;
                                cond_d     = 1'b0;
                                hlt_d      = 1'b1;
                                illegal_d  = 1'b1;
`endif
                                wr_rd_d    = 1'b0;
                                wr_fl_d    = 1'b0;
                            end else begin
                                end_inst_d = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    ex_state_d = CU_IDLE;
                end
            end
            CU_PEND: begin
                if (squash_s || commit_s) begin
                    // Squash drops the instruction; commit writes it back first
                    if (commit_s && wr_rd_q) begin
                        regs_d[rd_idx_q] = res_q;
                    end else begin
                        regs_d = regs_q;
                    end
                    if (commit_s && wr_fl_q) begin
                        z_d = z_new_q;
                        c_d = c_new_q;
                    end else begin
                        z_d = z_q;
                        c_d = c_q;
                    end
                    ex_state_d    = CU_IDLE;
                    wr_rd_d       = 1'b0;
                    wr_fl_d       = 1'b0;
                    end_inst_d    = 1'b0;
                    jmp_inst_d    = 1'b0;
                    jmp_address_d = 8'h00;
                    cond_d        = 1'b0;
                    out_valid_d   = 1'b0;
                end else begin
                    ex_state_d = CU_PEND;
                end
            end
            default: ex_state_d = CU_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_state_q    <= CU_IDLE;
            regs_q        <= '0;
            z_q           <= 1'b0;
            c_q           <= 1'b0;
            hlt_q         <= 1'b0;
            rd_idx_q      <= 2'b00;
            res_q         <= 8'h00;
            z_new_q       <= 1'b0;
            c_new_q       <= 1'b0;
            wr_rd_q       <= 1'b0;
            wr_fl_q       <= 1'b0;
            end_inst_q    <= 1'b0;
            jmp_inst_q    <= 1'b0;
            jmp_address_q <= 8'h00;
            cond_q        <= 1'b0;
            out_data_q    <= 8'h00;
            out_valid_q   <= 1'b0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            illegal_q     <= 1'b0;
`endif
        end else begin
            ex_state_q    <= ex_state_d;
            regs_q        <= regs_d;
            z_q           <= z_d;
            c_q           <= c_d;
            hlt_q         <= hlt_d;
            rd_idx_q      <= rd_idx_d;
            res_q         <= res_d;
            z_new_q       <= z_new_d;
            c_new_q       <= c_new_d;
            wr_rd_q       <= wr_rd_d;
            wr_fl_q       <= wr_fl_d;
            end_inst_q    <= end_inst_d;
            jmp_inst_q    <= jmp_inst_d;
            jmp_address_q <= jmp_address_d;
            cond_q        <= cond_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            illegal_q     <= illegal_d;
`endif
        end
    end

    assign bus.end_inst       = end_inst_q;
    assign bus.jmp_inst       = jmp_inst_q;
    assign bus.jmp_address    = jmp_address_q;
    assign bus.inst_condition = cond_q;
    assign bus.hlt_inst       = hlt_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_valid      = out_valid_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_op     = illegal_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// ----------------------------------------------------------------------------
// tb_cpu_control_unit
// Directed bench: an ISA-level model predicts the control outputs of every
// instruction, the prediction is queued when the instruction is driven and
// popped when the clks[1] cycle is observed.
// ----------------------------------------------------------------------------
module tb_cpu_control_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic       end_i;
        logic       jmp;
        logic       cond;
        logic [7:0] addr;
        logic       ov;
        logic [7:0] od;
        logic       hlt;
        logic       ill;
    } exp_t;

    logic clk;
    logic reset;
    cpu_ctrl_if bus ();

    cpu_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [7:0] mregs [4];
    logic       mz, mc, mhalt, mill;
    logic [7:0] mout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [1:0] rd,
                                       input logic [7:0] imm, input logic [1:0] rs);
        mk = {op, 6'b000000, rd, imm, 6'b000000, rs};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        mz = 1'b0; mc = 1'b0; mhalt = 1'b0; mill = 1'b0; mout = 8'h00;
    endtask

    // Predict the clks[1]-cycle outputs and update the model
    task automatic model_push(input logic [31:0] ir_v);
        exp_t       e;
        logic [7:0] op, a, b, imm, r;
        logic [8:0] t9;
        logic [1:0] rd;
        op  = ir_v[31:24]; rd = ir_v[17:16]; imm = ir_v[15:8];
        a   = mregs[rd];   b  = mregs[ir_v[1:0]];
        e   = '0;
        e.od = mout;
        if (mhalt) begin
            e.hlt = 1'b1; e.ill = mill;
        end else begin
            e.end_i = 1'b1; e.cond = 1'b1;
            case (op)
                8'h01: mregs[rd] = imm;
                8'h02: mregs[rd] = b;
                8'h03: begin t9 = {1'b0, a} + {1'b0, b}; mregs[rd] = t9[7:0];
                             mc = t9[8]; mz = (t9[7:0] == 8'h00); end
                8'h04, 8'h08: begin r = a - b; mc = (a < b); mz = (r == 8'h00);
                             if (op == 8'h04) mregs[rd] = r; end
                8'h05: begin r = a & b; mregs[rd] = r; mc = 1'b0; mz = (r == 8'h00); end
                8'h06: begin r = a | b; mregs[rd] = r; mc = 1'b0; mz = (r == 8'h00); end
                8'h07: begin r = a ^ b; mregs[rd] = r; mc = 1'b0; mz = (r == 8'h00); end
                8'h09: begin e.jmp = 1'b1; e.addr = imm; end
                8'h0A: begin e.jmp = 1'b1; e.addr = imm; e.cond = mz; end
                8'h0B: begin e.jmp = 1'b1; e.addr = imm; e.cond = !mz; end
                8'h0C: begin e.jmp = 1'b1; e.addr = imm; e.cond = mc; end
                8'h0D: begin e.ov = 1'b1; e.od = b; mout = b; end
                8'hFF: begin e.end_i = 1'b0; e.cond = 1'b0; e.hlt = 1'b1; mhalt = 1'b1; end
                8'h00: e.end_i = 1'b1;
                default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    e.end_i = 1'b0; e.cond = 1'b0; e.hlt = 1'b1; e.ill = 1'b1;
                    mhalt = 1'b1; mill = 1'b1;
`endif
                end
            endcase
        end
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_end0"},  {31'd0, bus.end_inst},       32'd0);
        chk({tag, "_jmp0"},  {31'd0, bus.jmp_inst},       32'd0);
        chk({tag, "_cond0"}, {31'd0, bus.inst_condition}, 32'd0);
        chk({tag, "_addr0"}, {24'd0, bus.jmp_address},    32'd0);
        chk({tag, "_ov0"},   {31'd0, bus.out_valid},      32'd0);
        chk({tag, "_hlt"},   {31'd0, bus.hlt_inst},       {31'd0, mhalt});
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        chk({tag, "_ill"},   {31'd0, bus.illegal_op},     {31'd0, mill});
`endif
    endtask

    // Drive one instruction (step0 cycle then step1 cycle) and score it
    task automatic issue(input string tag, input logic [31:0] ir_v);
        exp_t e;
        model_push(ir_v);
        bus.ir = ir_v; bus.state = ST_EXEC; bus.clks = 16'h0001;
        @(posedge clk); #1;
        bus.clks = 16'h0002;
        e = exp_q.pop_front();
        chk({tag, "_end"},  {31'd0, bus.end_inst},       {31'd0, e.end_i});
        chk({tag, "_jmp"},  {31'd0, bus.jmp_inst},       {31'd0, e.jmp});
        chk({tag, "_cond"}, {31'd0, bus.inst_condition}, {31'd0, e.cond});
        chk({tag, "_addr"}, {24'd0, bus.jmp_address},    {24'd0, e.addr});
        chk({tag, "_ov"},   {31'd0, bus.out_valid},      {31'd0, e.ov});
        chk({tag, "_od"},   {24'd0, bus.out_data},       {24'd0, e.od});
        chk({tag, "_hlt1"}, {31'd0, bus.hlt_inst},       {31'd0, e.hlt});
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        chk({tag, "_ill1"}, {31'd0, bus.illegal_op},     {31'd0, e.ill});
`endif
        @(posedge clk); #1;
        bus.clks = 16'h0000;
        check_idle({tag, "_post"});
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.clks = 16'h0000; bus.state = ST_RESET; bus.ir = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b0; bus.ir = 32'h0; bus.clks = 16'h0000; bus.state = ST_RESET;
        model_reset();
        do_reset();
        check_idle("rst");
        chk("rst_od", {24'd0, bus.out_data}, 32'd0);

        // Basic load/add
        issue("ldi1", mk(OP_LDI, 2'd1, 8'h05, 2'd0));
        issue("ldi2", mk(OP_LDI, 2'd2, 8'h03, 2'd0));
        issue("add",  mk(OP_ADD, 2'd1, 8'h00, 2'd2));
        issue("out1", mk(OP_OUT, 2'd0, 8'h00, 2'd1));
        chk("add_res", {24'd0, bus.out_data}, 32'h08);
        issue("jz_nz", mk(OP_JZ, 2'd0, 8'h10, 2'd0));
        issue("jc_nc", mk(OP_JC, 2'd0, 8'h11, 2'd0));

        // ADD overflow to zero
        issue("ldiff", mk(OP_LDI, 2'd1, 8'hFF, 2'd0));
        issue("ldi01", mk(OP_LDI, 2'd2, 8'h01, 2'd0));
        issue("addov", mk(OP_ADD, 2'd1, 8'h00, 2'd2));
        issue("jz20",  mk(OP_JZ, 2'd0, 8'h20, 2'd0));
        issue("jc_ov", mk(OP_JC, 2'd0, 8'h21, 2'd0));
        issue("outov", mk(OP_OUT, 2'd0, 8'h00, 2'd1));
        chk("addov_res", {24'd0, bus.out_data}, 32'h00);

        // CMP with borrow
        issue("ldi3",  mk(OP_LDI, 2'd1, 8'h03, 2'd0));
        issue("ldi5",  mk(OP_LDI, 2'd2, 8'h05, 2'd0));
        issue("cmp",   mk(OP_CMP, 2'd1, 8'h00, 2'd2));
        issue("jc40",  mk(OP_JC,  2'd0, 8'h40, 2'd0));
        issue("jnz",   mk(OP_JNZ, 2'd0, 8'h41, 2'd0));
        issue("jz0",   mk(OP_JZ,  2'd0, 8'h42, 2'd0));
        issue("outcmp", mk(OP_OUT, 2'd0, 8'h00, 2'd1));
        chk("cmp_keep", {24'd0, bus.out_data}, 32'h03);

        // Remaining ALU ops and moves
        issue("sub",  mk(OP_SUB, 2'd2, 8'h00, 2'd1));
        issue("outs", mk(OP_OUT, 2'd0, 8'h00, 2'd2));
        issue("and",  mk(OP_AND, 2'd2, 8'h00, 2'd1));
        issue("or",   mk(OP_OR,  2'd2, 8'h00, 2'd1));
        issue("xor",  mk(OP_XOR, 2'd2, 8'h00, 2'd1));
        issue("jzx",  mk(OP_JZ,  2'd0, 8'h50, 2'd0));
        issue("mov",  mk(OP_MOV, 2'd0, 8'h00, 2'd1));
        issue("outm", mk(OP_OUT, 2'd0, 8'h00, 2'd0));
        issue("jmp",  mk(OP_JMP, 2'd0, 8'h7F, 2'd0));
        issue("nop",  mk(OP_NOP, 2'd0, 8'h00, 2'd0));

        // Squash: leave EXEC while pending (ADD would set Z=1,C=1)
        issue("ldi80", mk(OP_LDI, 2'd1, 8'h80, 2'd0));
        bus.ir = mk(OP_ADD, 2'd1, 8'h00, 2'd1); bus.state = ST_EXEC; bus.clks = 16'h0001;
        @(posedge clk); #1;
        bus.state = ST_FETCH; bus.clks = 16'h0002;
        @(posedge clk); #1;
        bus.clks = 16'h0000;
        check_idle("squash");
        issue("sq_out", mk(OP_OUT, 2'd0, 8'h00, 2'd1));
        issue("sq_jc",  mk(OP_JC,  2'd0, 8'h01, 2'd0));

        // clks[0] outside EXEC, then clks[1] with nothing pending
        bus.ir = mk(OP_LDI, 2'd1, 8'h99, 2'd0); bus.state = ST_FETCH; bus.clks = 16'h0001;
        @(posedge clk); #1;
        check_idle("noexec");
        bus.state = ST_EXEC; bus.clks = 16'h0002;
        @(posedge clk); #1;
        bus.clks = 16'h0000;
        check_idle("nopend");
        issue("ne_out", mk(OP_OUT, 2'd0, 8'h00, 2'd1));

        // Reset in the step0->step1 gap of an ADD
        issue("ldi11", mk(OP_LDI, 2'd1, 8'h11, 2'd0));
        bus.ir = mk(OP_ADD, 2'd1, 8'h00, 2'd1); bus.clks = 16'h0001;
        @(posedge clk); #1;
        bus.clks = 16'h0002; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.clks = 16'h0000;
        model_reset();
        check_idle("midrst");
        issue("mr_out", mk(OP_OUT, 2'd0, 8'h00, 2'd1));

        // Undefined opcode
        issue("ill", mk(8'h7E, 2'd1, 8'h33, 2'd0));
        issue("ill_after", mk(OP_LDI, 2'd1, 8'h44, 2'd0));
        do_reset();

        // OUT then HLT, sticky halt, then reset
        issue("ldia5", mk(OP_LDI, 2'd3, 8'hA5, 2'd0));
        issue("outa5", mk(OP_OUT, 2'd0, 8'h00, 2'd3));
        chk("outa5_lit", {24'd0, bus.out_data}, 32'hA5);
        issue("hlt",   mk(OP_HLT, 2'd0, 8'h00, 2'd0));
        issue("h_ldi", mk(OP_LDI, 2'd3, 8'h00, 2'd0));
        issue("h_out", mk(OP_OUT, 2'd0, 8'h00, 2'd3));
        chk("hlt_lit", {31'd0, bus.hlt_inst}, 32'd1);
        do_reset();
        check_idle("rst2");
        chk("rst2_od", {24'd0, bus.out_data}, 32'd0);
        issue("r_out", mk(OP_OUT, 2'd0, 8'h00, 2'd3));
        chk("r_out_lit", {24'd0, bus.out_data}, 32'h00);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
